debounce_two_input: RTL

Upstream conditioning stage for the two-input gate datapath. It takes two raw, asynchronous board inputs (switches or buttons), synchronizes each one to `clk`, and debounces it with a per-channel stability counter. It then drives clean levels `in1_clean` / `in2_clean` directly into the gate's `in1` / `in2`. One-cycle edge pulses are also provided so later stages can count or log transitions.

---
 rtl/debounce_pkg.sv | 24 ++
 rtl/debounce_channel.sv | 111 +++++++++++
 rtl/debounce_two_input.sv | 56 +++++
 3 files changed

// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared types and constants for the two-channel input
//               debouncer: per-channel FSM state encoding, the default
//               stability window, and the short window used in simulation.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

  // Per-channel debounce FSM state, explicit 1-bit encoding.
  typedef enum logic [0:0] {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } deb_state_e;

  // Default number of consecutive synchronized cycles a new level must hold.
  localparam int c_DEFAULT_DEBOUNCE_CYCLES = 16;

  // Short window so simulation exercises the full behaviour quickly.
  localparam int c_SIM_DEBOUNCE_CYCLES = 4;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : One debounced input bit: 2-flop synchronizer, stability
//               counter FSM, registered clean level and one-cycle edge pulses.
// Ports       : clk     - system clock, rising edge
//               rst_n   - asynchronous active-low reset
//               i_raw   - raw asynchronous input
//               o_clean - debounced level (registered)
//               o_rise  - one-cycle pulse when o_clean goes 0->1
//               o_fall  - one-cycle pulse when o_clean goes 1->0
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_clean,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_clean;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_cnt;
  deb_state_e       r_state;

  logic             w_diff;
  logic             w_done;

  // Two-flop synchronizer for the asynchronous board input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_diff = r_sync2 ^ r_clean;
  // The current mismatching cycle is the last one the window requires.
  assign w_done = w_diff && (r_cnt == c_CNT_LAST);

  // The mismatch seen in STABLE already counts as the first cycle of the
  // window, so the counter is loaded with 1 on entry to PENDING. With a
  // window of one cycle w_done is true immediately and the counter stays 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= STABLE;
      r_cnt   <= '0;
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        STABLE: begin
          if (w_done) begin
            r_clean <= r_sync2;
            r_rise  <= r_sync2;
            r_fall  <= ~r_sync2;
            r_cnt   <= '0;
          end else if (w_diff) begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= PENDING;
          end else begin
            r_cnt   <= '0;
          end
        end
        PENDING: begin
          if (!w_diff) begin
            // Input returned to the committed level: glitch rejected.
            r_cnt   <= '0;
            r_state <= STABLE;
          end else if (w_done) begin
            r_clean <= r_sync2;
            r_rise  <= r_sync2;
            r_fall  <= ~r_sync2;
            r_cnt   <= '0;
            r_state <= STABLE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= STABLE;
        end
      endcase
    end
  end

  assign o_clean = r_clean;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/debounce_two_input.sv
`default_nettype none
// ============================================================================
// Module      : debounce_two_input
// Description : Conditioning stage for the two-input gate: two independent
//               debounce channels producing clean levels and edge pulses.
// Ports       : clk, rst_n           - clock, asynchronous active-low reset
//               in1_raw, in2_raw     - raw asynchronous inputs
//               in1_clean, in2_clean - debounced registered levels
//               in1_rise, in2_rise   - one-cycle 0->1 pulses
//               in1_fall, in2_fall   - one-cycle 1->0 pulses
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_two_input
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in1_raw,
  input  logic in2_raw,
  output logic in1_clean,
  output logic in2_clean,
  output logic in1_rise,
  output logic in2_rise,
  output logic in1_fall,
  output logic in2_fall
);

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_ch1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (in1_raw),
    .o_clean (in1_clean),
    .o_rise  (in1_rise),
    .o_fall  (in1_fall)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_ch2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (in2_raw),
    .o_clean (in2_clean),
    .o_rise  (in2_rise),
    .o_fall  (in2_fall)
  );

endmodule : debounce_two_input
`default_nettype wire
